sd_spi_cmd_engine: RTL and testbench

SD_SPI_CMD_ENGINE -- requirements
Module: sd_spi_cmd_engine

---
 rtl/sd_spi_pkg.sv | 40 ++++
 rtl/sd_crc7.sv | 31 +++
 rtl/sd_spi_cmd_engine.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sd_spi_cmd_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD SPI-mode command engine.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SEND,
    S_POLL,
    S_EXT,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam int unsigned R1_IN_IDLE     = 0;
  localparam int unsigned R1_ERASE_RESET = 1;
  localparam int unsigned R1_ILLEGAL_CMD = 2;
  localparam int unsigned R1_CRC_ERR     = 3;
  localparam int unsigned R1_ERASE_SEQ   = 4;
  localparam int unsigned R1_ADDR_ERR    = 5;
  localparam int unsigned R1_PARAM_ERR   = 6;
  localparam int unsigned R1_START       = 7;

  localparam int unsigned PRE_BITS   = 8;
  localparam int unsigned FRAME_BITS = 48;
  localparam int unsigned CRC_START  = 40;
  localparam int unsigned EXT_BITS   = 32;
  localparam int unsigned POST_BITS  = 8;

  // A response byte is an R1 token once its start bit reads 0.
  function automatic logic r1_valid(input logic [7:0] b);
    return !b[R1_START];
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) over the command frame, MSB first.
module sd_crc7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = bit_i ^ crc_q[6];
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SD card SPI-mode (mode 0) command engine: frame send, R1 poll, optional 32-bit tail, retries.
// Define SD_CMD_CRC7_EN to generate the frame CRC7 internally instead of using cmd_crc.
module sd_spi_cmd_engine
  import sd_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_args,
  input  logic [7:0]  cmd_crc,
  input  logic        resp_long,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [7:0]  response_flags,
  output logic [31:0] response_data,
  input  logic        D0,
  output logic        D1,
  output logic        CS,
  output logic        SD_CLK
);

  localparam int unsigned DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BYW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned RTW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BYW-1:0] BY_LAST  = BYW'(RESP_TIMEOUT - 1);
  localparam logic [BYW-1:0] BY_TMO   = BYW'(RESP_TIMEOUT);
  localparam logic [RTW-1:0] RT_MAX   = RTW'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             d1_q, d1_d;
  logic [5:0]       bit_q, bit_d;
  logic [BYW-1:0]   byte_q, byte_d;
  logic [RTW-1:0]   retry_q, retry_d;
  logic [39:0]      frame_q, frame_d;
  logic             long_q, long_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       flags_q, flags_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;

  logic             active, tick, rise, fall;
  logic [5:0]       bit_nx, tx_idx;
  logic             tx_bit;
  logic [7:0]       crc_byte;

  assign active = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tick   = active && (div_q == DIV_LAST);
  assign rise   = tick && !sclk_q;
  assign fall   = tick && sclk_q;
  assign bit_nx = bit_q + 6'd1;
  assign tx_idx = 6'd47 - bit_nx;
  assign tx_bit = (bit_nx >= 6'(CRC_START)) ? crc_byte[tx_idx[2:0]] : frame_q[tx_idx - 6'd8];

`ifdef SD_CMD_CRC7_EN
  logic [6:0] crc7_w;

  // CRC accumulates each frame bit as it is clocked out, so it is complete by bit 40.
  sd_crc7 u_crc7 (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == S_PRE),
    .en_i  (rise && (state_q == S_SEND) && (bit_q < 6'(CRC_START))),
    .bit_i (d1_q),
    .crc_o (crc7_w)
  );

  assign crc_byte = {crc7_w, 1'b1};
`else
  logic [7:0] crcb_q, crcb_d;

  assign crc_byte = crcb_q;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    d1_d    = d1_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    retry_d = retry_q;
    frame_d = frame_q;
    long_d  = long_q;
    rx_d    = rx_q;
    flags_d = flags_q;
    data_d  = data_q;
    err_d   = err_q;
`ifndef SD_CMD_CRC7_EN
    crcb_d  = crcb_q;
`endif

    if (active) begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) sclk_d = ~sclk_q;
    end
    if (rise && state_q == S_POLL) rx_d   = {rx_q[6:0], D0};
    if (rise && state_q == S_EXT)  data_d = {data_q[30:0], D0};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRE;
          frame_d = {2'b01, cmd_index, cmd_args};
          long_d  = resp_long;
`ifndef SD_CMD_CRC7_EN
          crcb_d  = {cmd_crc[7:1], 1'b1};
`endif
          div_d   = '0;
          sclk_d  = 1'b0;
          cs_d    = 1'b0;
          d1_d    = 1'b1;
          bit_d   = '0;
          byte_d  = '0;
          retry_d = '0;
          err_d   = 1'b0;
          flags_d = 8'hFF;
          data_d  = '0;
        end
      end
      S_PRE: begin
        if (fall) begin
          if (bit_q == 6'(PRE_BITS - 1)) begin
            state_d = S_SEND;
            bit_d   = '0;
            d1_d    = frame_q[39];
          end else begin
            bit_d = bit_nx;
          end
        end
      end
      S_SEND: begin
        if (fall) begin
          if (bit_q == 6'(FRAME_BITS - 1)) begin
            state_d = S_POLL;
            bit_d   = '0;
            byte_d  = '0;
            d1_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            d1_d  = tx_bit;
          end
        end
      end
      S_POLL: begin
        if (fall) begin
          if (bit_q == 6'd7) begin
            bit_d = '0;
            if (r1_valid(rx_q)) begin
              flags_d = rx_q;
              state_d = long_q ? S_EXT : S_POST;
              cs_d    = !long_q;
            end else if (byte_q == BY_LAST) begin
              // byte_q parked at RESP_TIMEOUT marks the attempt as timed out for POST.
              byte_d  = BY_TMO;
              state_d = S_POST;
              cs_d    = 1'b1;
            end else begin
              byte_d = byte_q + BYW'(1);
            end
          end else begin
            bit_d = bit_nx;
          end
        end
      end
      S_EXT: begin
        if (fall) begin
          if (bit_q == 6'(EXT_BITS - 1)) begin
            state_d = S_POST;
            bit_d   = '0;
            cs_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
          end
        end
      end
      S_POST: begin
        if (fall) begin
          if (bit_q == 6'(POST_BITS - 1)) begin
            bit_d = '0;
            if (byte_q == BY_TMO) begin
              if (retry_q < RT_MAX) begin
                retry_d = retry_q + RTW'(1);
                byte_d  = '0;
                state_d = S_PRE;
                cs_d    = 1'b0;
              end else begin
                err_d   = 1'b1;
                flags_d = 8'hFF;
                state_d = S_DONE;
              end
            end else begin
              state_d = S_DONE;
            end
          end else begin
            bit_d = bit_nx;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      d1_q    <= 1'b1;
      bit_q   <= '0;
      byte_q  <= '0;
      retry_q <= '0;
      frame_q <= '0;
      long_q  <= 1'b0;
      rx_q    <= '0;
      flags_q <= 8'hFF;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifndef SD_CMD_CRC7_EN
      crcb_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      d1_q    <= d1_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      retry_q <= retry_d;
      frame_q <= frame_d;
      long_q  <= long_d;
      rx_q    <= rx_d;
      flags_q <= flags_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifndef SD_CMD_CRC7_EN
      crcb_q  <= crcb_d;
`endif
    end
  end

  assign busy           = active;
  assign done           = (state_q == S_DONE);
  assign err_timeout    = err_q;
  assign response_flags = flags_q;
  assign response_data  = data_q;
  assign D1             = d1_q;
  assign CS             = cs_q;
  assign SD_CLK         = sclk_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Scoreboard bench for sd_spi_cmd_engine with a behavioural SPI-mode card.
module tb_sd_spi_cmd_engine;
  import sd_spi_pkg::*;

  typedef struct {
    logic [7:0]  flags;
    logic [31:0] data;
    logic        err;
    int          frames;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, resp_long;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_args;
  logic [7:0]  cmd_crc;
  logic        busy, done, err_timeout;
  logic [7:0]  response_flags;
  logic [31:0] response_data;
  logic        D0 = 1'b1;
  logic        D1, CS, SD_CLK;

  int checks = 0, errors = 0;
  int done_cnt = 0, exp_done = 0;
  int frames_seen = 0, frames_mark = 0;
  int win_bits = 0;
  logic [55:0] win_sr = '0;
  logic [7:0]  card_q[$];
  exp_t        exp_q[$];
  logic [47:0] fexp_q[$];
  exp_t        mon_e;

  sd_spi_cmd_engine #(.CLK_DIV(2), .RESP_TIMEOUT(8), .MAX_RETRIES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_args(cmd_args),
    .cmd_crc(cmd_crc), .resp_long(resp_long), .busy(busy), .done(done),
    .err_timeout(err_timeout), .response_flags(response_flags), .response_data(response_data),
    .D0(D0), .D1(D1), .CS(CS), .SD_CLK(SD_CLK)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] tb_crc7(input logic [39:0] d);
    logic [6:0] c = '0;
    logic fb;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic card_bit(input int k);
    int j;
    logic [7:0] b;
    if (k < 56) return 1'b1;
    j = k - 56;
    if (j / 8 >= card_q.size()) return 1'b1;
    b = card_q[j / 8];
    return b[7 - (j % 8)];
  endfunction

  // Card: capture MOSI on SD_CLK rise while selected; window closes when CS rises.
  always @(posedge SD_CLK or posedge CS) begin
    if (CS) begin
      if (win_bits >= 56) begin
        frames_seen++;
        if (fexp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%h required=none", win_sr[47:0]);
        end else begin
          chk("frame", win_sr[47:0], fexp_q.pop_front());
        end
      end
      win_bits = 0;
    end else begin
      if (win_bits < 56) win_sr = {win_sr[54:0], D1};
      win_bits++;
    end
  end

  always @(negedge SD_CLK) begin
    if (CS) D0 = 1'b1;
    else    D0 = card_bit(win_bits);
  end

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("flags", response_flags, mon_e.flags);
        chk("data", response_data, mon_e.data);
        chk("err_timeout", err_timeout, mon_e.err);
        chk("busy_at_done", busy, 1'b0);
        chk("frames_per_cmd", frames_seen - frames_mark, mon_e.frames);
      end
      frames_mark = frames_seen;
    end
  end

  task automatic expect_cmd(input logic [47:0] f, input int n, input logic [7:0] fl,
                            input logic [31:0] dt, input logic er);
    exp_t e;
    for (int i = 0; i < n; i++) fexp_q.push_back(f);
    e.flags = fl; e.data = dt; e.err = er; e.frames = n;
    exp_q.push_back(e);
    exp_done++;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] args, input logic [7:0] crc,
                       input logic lng);
    @(negedge clk);
    cmd_index = idx; cmd_args = args; cmd_crc = crc; resp_long = lng; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd_index = ~idx; cmd_args = ~args; cmd_crc = ~crc; resp_long = ~lng;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 6000 && done_cnt < exp_done; i++) @(posedge clk);
    if (done_cnt < exp_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    int d0;
    reset = 1'b1; start = 1'b0; cmd_index = '0; cmd_args = '0; cmd_crc = '0; resp_long = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", CS, 1'b1);
    chk("rst_sdclk", SD_CLK, 1'b0);
    chk("rst_d1", D1, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_flags", response_flags, 8'hFF);
    chk("rst_data", response_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // CMD0, R1 arrives in the second polled byte
    card_q = '{8'hFF, 8'h01};
    expect_cmd(48'h40_0000_0000_95, 1, 8'h01, 32'h0, 1'b0);
    issue(CMD0, 32'h0, 8'h95, 1'b0);
    wait_done("cmd0");

    // CMD8 with 32-bit tail
    card_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    expect_cmd(48'h48_0000_01AA_87, 1, 8'h01, 32'h0000_01AA, 1'b0);
    issue(CMD8, 32'h0000_01AA, 8'h87, 1'b1);
    wait_done("cmd8");

    // CMD0 with a zero CRC byte
    card_q = '{8'h01};
`ifdef SD_CMD_CRC7_EN
    f = 48'h40_0000_0000_95;
`else
    f = 48'h40_0000_0000_01;
`endif
    expect_cmd(f, 1, 8'h01, 32'h0, 1'b0);
    issue(CMD0, 32'h0, 8'h00, 1'b0);
    wait_done("cmd0_crc0");

    // CMD17, R1 = 00 in the third byte
    card_q = '{8'hFF, 8'hFF, 8'h00};
`ifdef SD_CMD_CRC7_EN
    f = {2'b01, CMD17, 32'h1234_5678, tb_crc7({2'b01, CMD17, 32'h1234_5678}), 1'b1};
`else
    f = 48'h51_1234_5678_55;
`endif
    expect_cmd(f, 1, 8'h00, 32'h0, 1'b0);
    issue(CMD17, 32'h1234_5678, 8'h54, 1'b0);
    wait_done("cmd17");

    // R1 in the last allowed polled byte
    card_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05};
    expect_cmd(48'h77_0000_0000_65, 1, 8'h05, 32'h0, 1'b0);
    issue(CMD55, 32'h0, 8'h65, 1'b0);
    wait_done("last_byte");

    // Card silent: four attempts then timeout
    card_q.delete();
    expect_cmd(48'h40_0000_0000_95, 4, 8'hFF, 32'h0, 1'b1);
    issue(CMD0, 32'h0, 8'h95, 1'b0);
    wait_done("timeout");
    repeat (20) @(negedge clk);
    chk("err_held", err_timeout, 1'b1);
    chk("flags_held", response_flags, 8'hFF);

    // Asynchronous reset in the middle of the frame
    card_q = '{8'h01};
    issue(CMD8, 32'h0000_01AA, 8'h87, 1'b1);
    for (int i = 0; i < 2000 && win_bits < 20; i++) @(posedge clk);
    chk("reached_send", win_bits >= 20, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_cs", CS, 1'b1);
    chk("arst_sdclk", SD_CLK, 1'b0);
    chk("arst_d1", D1, 1'b1);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (300) @(negedge clk);
    chk("no_done_after_reset", done_cnt, d0);

    // Normal command after the reset
    card_q = '{8'h01};
    expect_cmd(48'h77_0000_0000_65, 1, 8'h01, 32'h0, 1'b0);
    issue(CMD55, 32'h0, 8'h65, 1'b0);
    wait_done("after_reset");

    // Start while busy and start during the done cycle are both ignored
    card_q = '{8'h01};
    expect_cmd(48'h40_0000_0000_95, 1, 8'h01, 32'h0, 1'b0);
    issue(CMD0, 32'h0, 8'h95, 1'b0);
    repeat (20) @(negedge clk);
    cmd_index = CMD17; cmd_args = 32'hDEAD_BEEF; cmd_crc = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = 0;
    for (int i = 0; i < 6000 && d0 == 0; i++) begin
      @(posedge clk);
      #1;
      if (done) d0 = 1;
    end
    chk("done_seen", d0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_after_done_start", busy, 1'b0);
    chk("cs_after_done_start", CS, 1'b1);
    repeat (600) @(negedge clk);
    chk("done_count", done_cnt, exp_done);
    chk("frames_pending", fexp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
